// File: rtl/ram_dp_be_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package ram_dp_be_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic int calc_nbytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_be_merge.sv
// Byte-lane merge: enabled lanes take wdata, the rest keep the old word.
module ram_be_merge
    import ram_dp_be_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int NBYTES     = calc_nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [NBYTES-1:0]     wbe_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < NBYTES; i++) begin
            if (wbe_i[i]) begin
                merged_o[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM: byte-enable write port, registered read port with
// valid strobe, and a clear sequencer that fills the array with INIT_VALUE.
module ram_dp_be
    import ram_dp_be_pkg::*;
#(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  ADDR_WIDTH = 3,
    parameter int unsigned         DEPTH      = 1 << ADDR_WIDTH,
    parameter int                  BYTE_WIDTH = 8,
    parameter int                  RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                 NBYTES     = calc_nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NBYTES-1:0]     wbe,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    // One extra counter bit so DEPTH == 2^ADDR_WIDTH is representable.
    localparam int unsigned        LAST_I  = DEPTH - 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LAST_W  = LAST_I[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    logic                  idle;
    logic                  w_in_range;
    logic                  r_in_range;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] merged;

    assign idle       = (state_q == IDLE);
    assign w_in_range = ({1'b0, waddr} < DEPTH_W);
    assign r_in_range = ({1'b0, raddr} < DEPTH_W);
    assign wr_en      = idle && we && (|wbe) && w_in_range;

    ram_be_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NBYTES     (NBYTES)
    ) u_merge (
        .old_i    (mem_q[waddr]),
        .wdata_i  (wdata),
        .wbe_i    (wbe),
        .merged_o (merged)
    );

    // Write-first mode forwards the merged word on a same-address collision.
    always_comb begin
        rdata_d = '0;
        if (r_in_range) begin
            if (RDW_MODE == RDW_WRITE_FIRST && wr_en && waddr == raddr) begin
                rdata_d = merged;
            end else begin
                rdata_d = mem_q[raddr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
        end else if (wr_en) begin
            mem_q[waddr] <= merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    rvalid_q <= 1'b0;
                    if (cnt_q == LAST_W) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
                    end
                end
                IDLE: begin
                    rvalid_q <= re;
                    if (re) begin
                        rdata_q <= rdata_d;
                    end
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy   = (state_q == CLEAR);
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: read-first, write-first and a 32-bit
// byte-lane instance with DEPTH smaller than the address space.
module tb_ram_dp_be;

    logic clk;
    logic rst;

    // shared inputs for the two 8-bit instances
    logic       clr_req, we, re;
    logic [2:0] waddr, raddr;
    logic [7:0] wdata;
    logic [0:0] wbe;
    logic       busy_a, rvalid_a, busy_b, rvalid_b;
    logic [7:0] rdata_a, rdata_b;

    // 32-bit instance
    logic        c_clr_req, c_we, c_re;
    logic [2:0]  c_waddr, c_raddr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wbe;
    logic        busy_c, rvalid_c;
    logic [31:0] rdata_c;

    int errors = 0;
    int checks = 0;

    ram_dp_be #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RDW_MODE(0),
                .INIT_VALUE(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
        .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

    ram_dp_be #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYTE_WIDTH(8), .RDW_MODE(1),
                .INIT_VALUE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b));

    ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(6), .BYTE_WIDTH(8), .RDW_MODE(0),
                .INIT_VALUE(32'h0)) dut_c (
        .clk(clk), .rst(rst), .clr_req(c_clr_req), .busy(busy_c),
        .we(c_we), .waddr(c_waddr), .wdata(c_wdata), .wbe(c_wbe),
        .re(c_re), .raddr(c_raddr), .rdata(rdata_c), .rvalid(rvalid_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write8(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d; wbe = 1'b1;
        step();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wbe = '0;
        c_clr_req = 1'b0; c_we = 1'b0; c_re = 1'b0;
        c_waddr = '0; c_raddr = '0; c_wdata = '0; c_wbe = '0;
        #1;
        check("rst_busy_a", busy_a, 1);
        check("rst_rdata_a", rdata_a, 0);
        check("rst_rvalid_a", rvalid_a, 0);
        check("rst_rdata_c", rdata_c, 0);
        step(); step();
        rst = 1'b0;

        // busy for DEPTH edges after reset release
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("init_busy_a_e%0d", k), busy_a, (k < 8) ? 1 : 0);
            check($sformatf("init_busy_c_e%0d", k), busy_c, (k < 6) ? 1 : 0);
        end

        // every word holds INIT_VALUE
        for (int i = 0; i < 8; i++) begin
            re = 1'b1; raddr = 3'(i);
            step();
            check($sformatf("init_rd_a_%0d", i), rdata_a, 8'hA5);
            check($sformatf("init_rv_a_%0d", i), rvalid_a, 1);
        end
        check("init_rd_b_7", rdata_b, 8'hA5);
        re = 1'b0;

        // read-during-write on addr 5
        write8(3'd5, 8'h0F);
        we = 1'b1; waddr = 3'd5; wdata = 8'hF0; wbe = 1'b1;
        re = 1'b1; raddr = 3'd5;
        step();
        we = 1'b0;
        check("rdw_read_first", rdata_a, 8'h0F);
        check("rdw_write_first", rdata_b, 8'hF0);
        step();
        check("rdw_after_a", rdata_a, 8'hF0);
        check("rdw_after_b", rdata_b, 8'hF0);
        re = 1'b0;

        // hold behaviour, plus wbe=0 must not write
        write8(3'd4, 8'h77);
        we = 1'b1; waddr = 3'd4; wdata = 8'h00; wbe = 1'b0;
        step();
        we = 1'b0;
        re = 1'b1; raddr = 3'd4;
        step();
        re = 1'b0;
        check("hold_rd_0", rdata_a, 8'h77);
        check("hold_rv_0", rvalid_a, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("hold_rd_%0d", k), rdata_a, 8'h77);
            check($sformatf("hold_rv_%0d", k), rvalid_a, 0);
        end

        // clr_req in IDLE; a read alongside it is still serviced
        write8(3'd1, 8'h3C);
        clr_req = 1'b1; re = 1'b1; raddr = 3'd1;
        step();
        clr_req = 1'b0;
        check("clr_same_cycle_rd", rdata_a, 8'h3C);
        check("clr_same_cycle_rv", rvalid_a, 1);
        check("clr_busy_0", busy_a, 1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) clr_req = 1'b1;
            step();
            clr_req = 1'b0;
            check($sformatf("clr_busy_e%0d", k), busy_a, (k < 8) ? 1 : 0);
            check($sformatf("clr_rv_e%0d", k), rvalid_a, 0);
        end
        check("clr_rd_held", rdata_a, 8'h3C);
        step();
        check("clr_after_rd", rdata_a, 8'hA5);
        check("clr_after_rv", rvalid_a, 1);
        re = 1'b0;

        // async reset mid-clear
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step(); step(); step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rdata", rdata_a, 0);
        check("mid_rst_rvalid", rvalid_a, 0);
        check("mid_rst_busy", busy_a, 1);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("mid_busy_e%0d", k), busy_a, (k < 8) ? 1 : 0);
        end

        // 32-bit byte-lane merge
        c_we = 1'b1; c_waddr = 3'd2; c_wdata = 32'h11223344; c_wbe = 4'b1111;
        step();
        c_wdata = 32'hAABBCCDD; c_wbe = 4'b0101;
        step();
        c_we = 1'b0;
        c_re = 1'b1; c_raddr = 3'd2;
        step();
        check("be_merge", rdata_c, 32'h11BB33DD);
        check("be_merge_rv", rvalid_c, 1);

        // out-of-range address on DEPTH=6 instance
        c_re = 1'b0;
        c_we = 1'b1; c_waddr = 3'd6; c_wdata = 32'hDEADBEEF; c_wbe = 4'b1111;
        step();
        c_we = 1'b0;
        c_re = 1'b1; c_raddr = 3'd6;
        step();
        check("oor_rd6", rdata_c, 32'h0);
        check("oor_rv6", rvalid_c, 1);
        c_raddr = 3'd2;
        step();
        check("oor_addr2_intact", rdata_c, 32'h11BB33DD);
        c_raddr = 3'd7;
        step();
        check("oor_rd7", rdata_c, 32'h0);
        c_re = 1'b0;
        step();
        check("c_rv_drop", rvalid_c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
